fp32_divider: RTL and testbench
===============================

// Module: fp32_divider
// PURPOSE
//  Multi-cycle IEEE-754 single-precision divider (resultDiv = A / B), the inverse
//  operation to the FPU's combinational multiplier. Shares its rounding-mode
//  encoding and error/overflow flag semantics.
//  Restoring division, IPC quotient bits per cycle, start/done handshake.
//  Sits beside the multiplier in the FPU datapath.
// PARAMETERS
//  IPC  1  quotient bits retired per DIVIDE cycle; legal values 1 or 2
//          D = 26/IPC divide cycles
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   synchronous, active-high
//  start        in   1   request; sampled only when busy=0
//  A            in   32  dividend, sampled with start
//  B            in   32  divisor, sampled with start
//  round_mode   in   2   00 +inf, 01 -inf, 10 nearest-even, 11 away-from-zero
//  busy         out  1   operation in flight
//  done         out  1   one-cycle pulse; result and flags valid
//  resultDiv    out  32  quotient; held until the next done
//  errorDiv     out  1   invalid op or divide-by-zero; held with resultDiv
//  overflowDiv  out  1   infinite result from a finite/inf path; held with resultDiv
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, resultDiv, errorDiv, overflowDiv = 0.
//   Reset mid-operation aborts the operation; no done is produced.
//  Handshake:
//   - On an edge with start=1 and busy=0, latch A, B and round_mode; busy=1 next cycle.
//   - start while busy=1 is ignored.
//   - start in the done cycle is accepted, because busy=0 in that cycle.
//  FSM: IDLE -> UNPACK -> (special ? OUT : DIVIDE) ; DIVIDE x D -> ROUND -> OUT -> IDLE.
//   - OUT: done=1 and busy=0 for exactly one cycle.
//   - Latency: done rises 2 edges after the start-sampling edge for special cases,
//     D+3 edges after it for the normal path.
//  Operands with E=0 are treated as signed zero (denormal flush). Sign = S_A ^ S_B.
//  Special cases (decided in UNPACK, checked in this order):
//   1. A is NaN -> A; errorDiv=1.
//   2. B is NaN -> B; errorDiv=1.
//   3. inf/inf or 0/0 -> {S, 8'hFF, 23'h400000}; errorDiv=1.
//   4. A is inf -> {S, 8'hFF, 0}; overflowDiv=1.
//   5. B is zero -> {S, 8'hFF, 0}; errorDiv=1.
//   6. A is zero or B is inf -> {S, 31'h0}; both flags 0.
//  Normal path:
//   - Exponent: 10-bit signed E = E_A - E_B + 127.
//   - M_A = {1, F_A}, M_B = {1, F_B}. If M_A < M_B: M_A <<= 1 and E -= 1.
//   - Division produces 26 quotient bits: 24 significand bits, then guard (G),
//     then round (R). Sticky = (final remainder != 0).
//   - Rounding increments the significand when:
//       00: S=0 and (G|R|sticky)
//       01: S=1 and (G|R|sticky)
//       10: G & (R | sticky | lsb)
//       11: G|R|sticky
//   - Carry out of the round increment: significand >>= 1 and E += 1.
//   - E >= 255 -> {S, 8'hFF, 0}; overflowDiv=1, errorDiv=0.
//   - E <= 0 -> {S, 31'h0}; both flags 0 (flush).
//   - Otherwise {S, E[7:0], sig[22:0]}; both flags 0.
//  Outputs change only in the OUT cycle or on reset.
// TESTING
//  1. A=0x40C00000, B=0x40000000, mode 10
//     -> resultDiv=0x40400000, flags 0, done at D+3 edges.
//  2. A=0x3F800000, B=0x40400000
//     -> mode 10: 0x3EAAAAAB; mode 01: 0x3EAAAAAA; mode 11: 0x3EAAAAAB.
//  3. A=0x3F800000, B=0x00000000
//     -> 0x7F800000, errorDiv=1, done 2 edges after start.
//     A=B=0 -> 0x7FC00000, errorDiv=1.
//  4. A=0x7F7FFFFF, B=0x3F000000 -> 0x7F800000, overflowDiv=1, errorDiv=0.
//  5. start pulsed again while busy with different operands
//     -> ignored; first result delivered, single done pulse.
//  6. Assert reset at DIVIDE cycle 5 -> no done; all outputs 0.
//     A new start after reset completes correctly.

Source files
------------

// File: rtl/fp32_divider_if.sv
// fp32_divider_if: start/done handshake, operands and results of the fp32 divider
// master drives start/A/B/round_mode; slave returns busy/done/resultDiv/errorDiv/overflowDiv
interface fp32_divider_if;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  round_mode;
  logic        busy;
  logic        done;
  logic [31:0] resultDiv;
  logic        errorDiv;
  logic        overflowDiv;
  modport master (output start, A, B, round_mode, input busy, done, resultDiv, errorDiv, overflowDiv);
  modport slave (input start, A, B, round_mode, output busy, done, resultDiv, errorDiv, overflowDiv);
endinterface

// File: rtl/fp32_divider.sv
// fp32_divider: multi-cycle restoring IEEE-754 single-precision divider, resultDiv = A / B
// clk, reset (sync, active-high); bus.slave carries start/A/B/round_mode in and
// busy/done/resultDiv/errorDiv/overflowDiv out. IPC (1 or 2) quotient bits per divide cycle.
module fp32_divider #(
  parameter int IPC = 1
) (
  input logic         clk,
  input logic         reset,
  fp32_divider_if.slave bus
);
  localparam int D = 26 / IPC;
  typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, OUT} state_t;
  state_t state_q, state_d;
  logic [31:0] a_q, b_q, pr_q, res_q;
  logic [1:0]  rm_q;
  logic [24:0] rem_q, rem_d, r1, r2, rem_init;
  logic [23:0] mb_q, ma, mb, sig;
  logic [25:0] q_q, q_d;
  logic [4:0]  cnt_q;
  logic signed [9:0] e_q, e_init, ef;
  logic [24:0] sum;
  logic [31:0] sp_res, n_res;
  logic pe_q, po_q, done_q, err_q, ovf_q;
  logic sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, ii_zz, special, sp_err, sp_ovf;
  logic lt, b1, b2, g, r, st, inc, n_ovf;
  always_comb begin
    sgn     = a_q[31] ^ b_q[31];
    a_nan   = &a_q[30:23] && |a_q[22:0];
    b_nan   = &b_q[30:23] && |b_q[22:0];
    a_inf   = &a_q[30:23] && ~|a_q[22:0];
    b_inf   = &b_q[30:23] && ~|b_q[22:0];
    a_zero  = ~|a_q[30:23];
    b_zero  = ~|b_q[30:23];
    ii_zz   = (a_inf & b_inf) | (a_zero & b_zero);
    special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    sp_res  = a_nan ? a_q : b_nan ? b_q : ii_zz ? {sgn, 8'hFF, 23'h400000} :
              (a_inf | b_zero) ? {sgn, 8'hFF, 23'h0} : {sgn, 31'h0};
    sp_err  = a_nan | b_nan | ii_zz | (b_zero & ~a_inf);
    sp_ovf  = ~a_nan & ~b_nan & ~ii_zz & a_inf;
    ma      = {1'b1, a_q[22:0]};
    mb      = {1'b1, b_q[22:0]};
    lt      = ma < mb;
    // Pre-shift the dividend so the first quotient bit is always 1
    rem_init = lt ? {ma, 1'b0} : {1'b0, ma};
    e_init  = $signed({2'b0, a_q[30:23]}) - $signed({2'b0, b_q[30:23]}) + 10'sd127 - (lt ? 10'sd1 : 10'sd0);
    b1      = rem_q >= {1'b0, mb_q};
    r1      = (b1 ? rem_q - {1'b0, mb_q} : rem_q) << 1;
    b2      = r1 >= {1'b0, mb_q};
    r2      = (b2 ? r1 - {1'b0, mb_q} : r1) << 1;
    rem_d   = IPC == 2 ? r2 : r1;
    q_d     = IPC == 2 ? {q_q[23:0], b1, b2} : {q_q[24:0], b1};
    sig     = q_q[25:2];
    g       = q_q[1];
    r       = q_q[0];
    st      = |rem_q;
    inc     = rm_q == 2'b00 ? ~sgn & (g | r | st) :
              rm_q == 2'b01 ? sgn & (g | r | st) :
              rm_q == 2'b10 ? g & (r | st | sig[0]) : (g | r | st);
    sum     = {1'b0, sig} + {24'b0, inc};
    ef      = e_q + (sum[24] ? 10'sd1 : 10'sd0);
    n_ovf   = ef >= 10'sd255;
    n_res   = n_ovf ? {sgn, 8'hFF, 23'h0} : ef <= 10'sd0 ? {sgn, 31'h0} :
              {sgn, ef[7:0], sum[24] ? sum[23:1] : sum[22:0]};
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.start ? UNPACK : IDLE;
      UNPACK:  state_d = special ? OUT : DIVIDE;
      DIVIDE:  state_d = cnt_q == 5'(D - 1) ? ROUND : DIVIDE;
      ROUND:   state_d = OUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      res_q   <= 32'h0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= state_q == OUT;
      if (state_q == OUT) begin
        res_q <= pr_q;
        err_q <= pe_q;
        ovf_q <= po_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.start) begin
      a_q  <= bus.A;
      b_q  <= bus.B;
      rm_q <= bus.round_mode;
    end
    if (state_q == UNPACK) begin
      rem_q <= rem_init;
      mb_q  <= mb;
      e_q   <= e_init;
      q_q   <= 26'h0;
      cnt_q <= 5'd0;
      pr_q  <= sp_res;
      pe_q  <= sp_err;
      po_q  <= sp_ovf;
    end
    if (state_q == DIVIDE) begin
      rem_q <= rem_d;
      q_q   <= q_d;
      cnt_q <= cnt_q + 5'd1;
    end
    if (state_q == ROUND) begin
      pr_q <= n_res;
      pe_q <= 1'b0;
      po_q <= n_ovf;
    end
  end
  assign bus.busy        = state_q != IDLE;
  assign bus.done        = done_q;
  assign bus.resultDiv   = res_q;
  assign bus.errorDiv    = err_q;
  assign bus.overflowDiv = ovf_q;
endmodule

// File: tb/tb_fp32_divider.sv
// tb_fp32_divider: directed and random checks of fp32_divider against an arithmetic reference model
module tb_fp32_divider;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  fp32_divider_if bus ();
  fp32_divider #(.IPC(1)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {special, overflow, error, result}, computed with whole-number division
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
    logic s;
    int ea, eb, e;
    longint ma, mb, num, q, sig;
    logic g, r, st, inc, an, bn, ai, bi, az, bz;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = ea == 255 && a[22:0] != 0;
    bn = eb == 255 && b[22:0] != 0;
    ai = ea == 255 && a[22:0] == 0;
    bi = eb == 255 && b[22:0] == 0;
    az = ea == 0;
    bz = eb == 0;
    if (an) return {3'b101, a};
    if (bn) return {3'b101, b};
    if ((ai && bi) || (az && bz)) return {3'b101, s, 8'hFF, 23'h400000};
    if (ai) return {3'b110, s, 8'hFF, 23'h0};
    if (bz) return {3'b101, s, 8'hFF, 23'h0};
    if (az || bi) return {3'b100, s, 31'h0};
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    e  = ea - eb + 127;
    if (ma < mb) begin
      num = ma << 26;
      e--;
    end else num = ma << 25;
    q   = num / mb;
    st  = (num % mb) != 0;
    sig = q >> 2;
    g   = q[1];
    r   = q[0];
    case (rm)
      2'b00: inc = !s && (g || r || st);
      2'b01: inc = s && (g || r || st);
      2'b10: inc = g && (r || st || sig[0]);
      default: inc = g || r || st;
    endcase
    sig = sig + longint'(inc);
    if (sig >= (longint'(1) << 24)) begin
      sig = sig >> 1;
      e++;
    end
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    if (e <= 0) return {3'b000, s, 31'h0};
    return {3'b000, s, 8'(e), sig[22:0]};
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm, input string tag, input int glitch);
    logic [34:0] exp;
    int n, lat;
    exp = model(a, b, rm);
    lat = exp[34] ? 2 : 29;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.round_mode = rm;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 0;
    while (n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (n == glitch) begin
        bus.start = 1'b1;
        bus.A = 32'h3F800000;
        bus.B = 32'h40400000;
      end else bus.start = 1'b0;
      if (bus.done) break;
    end
    bus.start = 1'b0;
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_res"}, bus.resultDiv, exp[31:0]);
    check({tag, "_err"}, 32'(bus.errorDiv), 32'(exp[32]));
    check({tag, "_ovf"}, 32'(bus.overflowDiv), 32'(exp[33]));
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_hold"}, bus.resultDiv, exp[31:0]);
  endtask

  function automatic logic [31:0] rnd_operand();
    logic [31:0] x;
    int k;
    x = $urandom;
    k = $urandom_range(0, 15);
    if (k == 0) x[30:23] = 8'h00;
    else if (k == 1) x[30:23] = 8'hFF;
    else if (k == 2) begin
      x[30:23] = 8'hFF;
      x[22:0] = 23'h0;
    end else if (k < 8) x[30:23] = 8'($urandom_range(100, 154));
    else if (x[30:23] == 8'h00 || x[30:23] == 8'hFF) x[30:23] = 8'h80;
    return x;
  endfunction

  initial begin
    int n, pulses;
    bus.start = 1'b0;
    bus.A = 32'h0;
    bus.B = 32'h0;
    bus.round_mode = 2'b10;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_res", bus.resultDiv, 32'h0);
    check("rst_flags", {30'h0, bus.errorDiv, bus.overflowDiv}, 32'h0);
    run_op(32'h40C00000, 32'h40000000, 2'b10, "six_by_two", 0);
    check("six_by_two_val", bus.resultDiv, 32'h40400000);
    run_op(32'h3F800000, 32'h40400000, 2'b10, "third_ne", 0);
    check("third_ne_val", bus.resultDiv, 32'h3EAAAAAB);
    run_op(32'h3F800000, 32'h40400000, 2'b01, "third_ni", 0);
    check("third_ni_val", bus.resultDiv, 32'h3EAAAAAA);
    run_op(32'h3F800000, 32'h40400000, 2'b11, "third_aw", 0);
    check("third_aw_val", bus.resultDiv, 32'h3EAAAAAB);
    run_op(32'h3F800000, 32'h00000000, 2'b10, "div_zero", 0);
    check("div_zero_val", bus.resultDiv, 32'h7F800000);
    run_op(32'h00000000, 32'h00000000, 2'b10, "zero_zero", 0);
    check("zero_zero_val", bus.resultDiv, 32'h7FC00000);
    run_op(32'h7F7FFFFF, 32'h3F000000, 2'b10, "ovf", 0);
    check("ovf_val", {bus.resultDiv[31:2], bus.overflowDiv, bus.errorDiv}, {30'h1FE00000, 2'b10});
    run_op(32'h00800000, 32'h4F000000, 2'b10, "flush", 0);
    run_op(32'h7F800000, 32'h3F800000, 2'b00, "inf_a", 0);
    run_op(32'h7FC12345, 32'h7F800000, 2'b00, "nan_a", 0);
    run_op(32'h3F800000, 32'h7F800001, 2'b00, "nan_b", 0);
    run_op(32'hBF800000, 32'h7F800000, 2'b00, "fin_inf", 0);
    run_op(32'h40C00000, 32'h40000000, 2'b10, "glitch", 4);
    check("glitch_val", bus.resultDiv, 32'h40400000);
    pulses = 0;
    repeat (35) begin
      @(posedge clk);
      #1;
      pulses += int'(bus.done);
    end
    check("glitch_extra_done", 32'(pulses), 32'd0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = 32'h40490FDB;
    bus.B = 32'h402DF854;
    bus.round_mode = 2'b10;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_res", bus.resultDiv, 32'h0);
    check("abort_flags", {30'h0, bus.errorDiv, bus.overflowDiv}, 32'h0);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      pulses += int'(bus.done);
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    run_op(32'h40490FDB, 32'h402DF854, 2'b10, "after_abort", 0);
    for (int i = 0; i < 150; i++) run_op(rnd_operand(), rnd_operand(), 2'($urandom_range(0, 3)), "rand", 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
